// File: rtl/instr_dispatch_fsm.sv
// Instruction dispatch controller: refills i_mem from DDR, reads a programme and hands each
// instruction to one execution unit. Optional EXEC watchdog is built when DISPATCH_TIMEOUT_EN is set.
module instr_dispatch_fsm #(
  parameter int unsigned INSTR_W     = 64,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned NUM_UNITS   = 4,
  parameter int unsigned RD_LATENCY  = 1,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 acc_enable,
  input  logic [ADDR_W:0]      prog_len,
  input  logic                 i_mem_full,
  input  logic [INSTR_W-1:0]   i_mem_rdata,
  output logic [ADDR_W-1:0]    i_mem_addr,
  output logic                 i_mem_rd_enable,
  output logic                 fetch_instruction_from_ddr,
  output logic [INSTR_W-1:0]   instr_data,
  output logic [NUM_UNITS-1:0] instr_valid,
  input  logic [NUM_UNITS-1:0] instr_ready,
  input  logic [NUM_UNITS-1:0] unit_done,
  output logic                 busy,
  output logic [15:0]          instr_cnt,
  output logic                 err_illegal,
  output logic                 err_timeout
);

  localparam int unsigned SEL_W = $clog2(NUM_UNITS);
  localparam int unsigned LAT_W = $clog2(RD_LATENCY + 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRead,
    StWait,
    StDispatch,
    StExec,
    StNext
  } state_e;

  state_e               state_q, state_d;
  logic                 full_q;
  logic [ADDR_W:0]      len_q, len_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [INSTR_W-1:0]   data_q, data_d;
  logic [15:0]          cnt_q, cnt_d;
  logic                 ill_q, ill_d;
  logic [LAT_W-1:0]     lat_q, lat_d;

  logic [SEL_W-1:0]     sel_q, sel_rd;
  logic [NUM_UNITS-1:0] unit_oh;
  logic                 sel_ok;
  logic                 last_addr;

  assign sel_q     = data_q[INSTR_W-1 -: SEL_W];
  assign sel_rd    = i_mem_rdata[INSTR_W-1 -: SEL_W];
  assign unit_oh   = NUM_UNITS'(1) << sel_q;
  assign sel_ok    = (32'(sel_rd) < NUM_UNITS);
  assign last_addr = ({1'b0, addr_q} == (len_q - (ADDR_W+1)'(1)));

`ifdef DISPATCH_TIMEOUT_EN
  logic [15:0] wd_q, wd_d;
  logic        to_q, to_d;
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    ill_d   = ill_q;
    lat_d   = lat_q;
`ifdef DISPATCH_TIMEOUT_EN
    wd_d    = wd_q;
    to_d    = to_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (acc_enable && (prog_len != '0)) begin
          len_d   = prog_len;
          addr_d  = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (full_q) state_d = StRead;
      end
      StRead: begin
        lat_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (lat_q == LAT_W'(RD_LATENCY - 1)) begin
          data_d = i_mem_rdata;
          // An unmapped unit select skips the word without counting it.
          if (sel_ok) begin
            state_d = StDispatch;
          end else begin
            ill_d   = 1'b1;
            state_d = StNext;
          end
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      StDispatch: begin
        if (|(instr_ready & unit_oh)) begin
          state_d = StExec;
`ifdef DISPATCH_TIMEOUT_EN
          wd_d    = '0;
`endif
        end
      end
      StExec: begin
        if (|(unit_done & unit_oh)) begin
          cnt_d   = cnt_q + 16'd1;
          state_d = StNext;
        end
`ifdef DISPATCH_TIMEOUT_EN
        else if (wd_q == 16'(TIMEOUT_CYC - 1)) begin
          to_d    = 1'b1;
          state_d = StIdle;
        end else begin
          wd_d = wd_q + 16'd1;
        end
`endif
      end
      StNext: begin
        if (last_addr) begin
          if (acc_enable) begin
            addr_d  = '0;
            state_d = StLoad;
          end else begin
            state_d = StIdle;
          end
        end else if (acc_enable) begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = StRead;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      full_q  <= 1'b0;
      len_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
      lat_q   <= '0;
`ifdef DISPATCH_TIMEOUT_EN
      wd_q    <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      full_q  <= i_mem_full;
      len_q   <= len_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
      lat_q   <= lat_d;
`ifdef DISPATCH_TIMEOUT_EN
      wd_q    <= wd_d;
      to_q    <= to_d;
`endif
    end
  end

  assign i_mem_addr                 = addr_q;
  assign i_mem_rd_enable            = (state_q == StRead);
  assign fetch_instruction_from_ddr = (state_q == StLoad) && !full_q;
  assign instr_data                 = data_q;
  assign instr_valid                = (state_q == StDispatch) ? unit_oh : '0;
  assign busy                       = (state_q != StIdle);
  assign instr_cnt                  = cnt_q;
  assign err_illegal                = ill_q;
`ifdef DISPATCH_TIMEOUT_EN
  assign err_timeout                = to_q;
`else
  assign err_timeout                = 1'b0;
`endif

endmodule

// File: tb/tb_instr_dispatch_fsm.sv
// Bench for instr_dispatch_fsm: transaction model of expected dispatches plus directed scenarios,
// on a 4-unit instance and a 3-unit instance with two-cycle read latency.
module tb_instr_dispatch_fsm;
  localparam int unsigned IW = 16, AW = 4, RDL = 1, RDL3 = 2;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, acc_enable = 1'b0, i_mem_full = 1'b0;
  logic [AW:0]   prog_len = '0;
  logic [IW-1:0] i_mem_rdata = '0, instr_data;
  logic [AW-1:0] i_mem_addr;
  logic          i_mem_rd_enable, fetch, busy, err_illegal, err_timeout;
  logic [3:0]    instr_valid, instr_ready = '0, unit_done = '0;
  logic [15:0]   instr_cnt;

  logic          acc3 = 1'b0, full3 = 1'b1;
  logic [AW:0]   len3 = '0;
  logic [IW-1:0] rdata3 = '0, data3, pipe3 = '0;
  logic [AW-1:0] addr3;
  logic          rd3, fetch3, busy3, ill3, to3;
  logic [2:0]    valid3, ready3 = '1, done3 = '0;
  logic [15:0]   cnt3;

  instr_dispatch_fsm #(.INSTR_W(IW), .ADDR_W(AW), .NUM_UNITS(4), .RD_LATENCY(RDL),
                       .TIMEOUT_CYC(16)) u_dut (
    .clk(clk), .rst(rst), .acc_enable(acc_enable), .prog_len(prog_len),
    .i_mem_full(i_mem_full), .i_mem_rdata(i_mem_rdata), .i_mem_addr(i_mem_addr),
    .i_mem_rd_enable(i_mem_rd_enable), .fetch_instruction_from_ddr(fetch),
    .instr_data(instr_data), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .unit_done(unit_done), .busy(busy), .instr_cnt(instr_cnt), .err_illegal(err_illegal),
    .err_timeout(err_timeout));

  instr_dispatch_fsm #(.INSTR_W(IW), .ADDR_W(AW), .NUM_UNITS(3), .RD_LATENCY(RDL3),
                       .TIMEOUT_CYC(16)) u_dut3 (
    .clk(clk), .rst(rst), .acc_enable(acc3), .prog_len(len3),
    .i_mem_full(full3), .i_mem_rdata(rdata3), .i_mem_addr(addr3),
    .i_mem_rd_enable(rd3), .fetch_instruction_from_ddr(fetch3),
    .instr_data(data3), .instr_valid(valid3), .instr_ready(ready3),
    .unit_done(done3), .busy(busy3), .instr_cnt(cnt3), .err_illegal(ill3),
    .err_timeout(to3));

  logic [IW-1:0] mem [16];
  logic [IW-1:0] mem3 [16];
  int checks = 0, errors = 0, cyc = 0;

  // Samples taken at the previous negedge
  logic          p_rd = 0, p_fetch = 0, p_rst = 1, p_rd3 = 0;
  logic [AW-1:0] p_addr = '0, p_addr3 = '0;
  logic [3:0]    p_valid = '0, p_ready = '0;
  logic [2:0]    p_valid3 = '0;

  // Responder / DDR knobs
  int         ready_delay = 0, done_delay = 0, rwait = 0, dwait = 0, fcnt = 0;
  bit         done_en = 1, pend = 0;
  logic [3:0] pend_unit = '0, distract = '0;

  // Model state
  int            q_unit[$];
  logic [IW-1:0] q_data[$];
  logic [15:0]   m_cnt = '0;
  bit            m_inflight = 0, rd_prev = 0;
  logic [3:0]    m_iunit = '0, valid_prev = '0;
  logic [IW-1:0] data_prev = '0;
  int            m_next = 0, rd_cyc = 0, hs_cnt = 0;
  int            rd_log[$], rd_cyc_log[$], a3_log[$];
  logic [3:0]    hs_log[$];
  logic [2:0]    v3_log[$];
  logic [IW-1:0] d3_log[$];

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flush();
    q_unit.delete();
    q_data.delete();
    m_inflight = 0;
    m_next = 0;
  endtask

  task automatic model_step();
    logic [3:0]    exp_v;
    logic [IW-1:0] w;
    if (rst) begin
      flush();
      m_cnt = '0;
      valid_prev = '0;
      rd_prev = 0;
    end else begin
      check_eq("instr_cnt", instr_cnt, m_cnt);
      if (i_mem_rd_enable) begin
        check_eq("rd_pulse", rd_prev, 0);
        check_eq("rd_addr", i_mem_addr, m_next);
        w = mem[i_mem_addr];
        q_unit.push_back(int'(w[15:14]));
        q_data.push_back(w);
        m_next = (m_next + 1) % int'(prog_len);
        rd_cyc = cyc;
        rd_log.push_back(int'(i_mem_addr));
        rd_cyc_log.push_back(cyc);
      end
      if (instr_valid != '0) begin
        if (valid_prev == '0) begin
          if (q_unit.size() == 0) begin
            check_eq("dispatch_unexpected", instr_valid, 0);
          end else begin
            exp_v = 4'b0001 << q_unit[0];
            check_eq("dispatch_unit", instr_valid, exp_v);
            check_eq("dispatch_data", instr_data, q_data[0]);
            check_eq("dispatch_latency", cyc - rd_cyc, RDL + 1);
          end
        end else begin
          check_eq("valid_hold", instr_valid, valid_prev);
          check_eq("data_hold", instr_data, data_prev);
        end
        if (|(instr_valid & instr_ready)) begin
          if (q_unit.size() != 0) begin
            void'(q_unit.pop_front());
            void'(q_data.pop_front());
          end
          m_inflight = 1;
          m_iunit = instr_valid;
          hs_cnt++;
          hs_log.push_back(instr_valid);
        end
      end
      if (m_inflight && |(unit_done & m_iunit)) begin
        m_cnt++;
        m_inflight = 0;
      end
      valid_prev = instr_valid;
      data_prev = instr_data;
      rd_prev = i_mem_rd_enable;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    if (p_rd) i_mem_rdata = mem[p_addr];
    rdata3 = pipe3;
    if (p_rd3) pipe3 = mem3[p_addr3];
    if (i_mem_full) begin
      i_mem_full = 1'b0;
      fcnt = 0;
    end else if (p_fetch) begin
      fcnt++;
      if (fcnt == 5) i_mem_full = 1'b1;
    end
    if (p_rst) pend = 0;
    else if (|(p_valid & p_ready)) begin
      pend = 1;
      pend_unit = p_valid;
      dwait = done_delay;
    end
    unit_done = '0;
    if (pend) begin
      if (dwait == 0) begin
        if (done_en) begin
          unit_done = pend_unit;
          pend = 0;
        end
      end else begin
        unit_done = distract;
        dwait--;
      end
    end
    if (instr_valid != '0) begin
      if (rwait < ready_delay) begin
        instr_ready = ~instr_valid;
        rwait++;
      end else begin
        instr_ready = '1;
      end
    end else begin
      instr_ready = '0;
      rwait = 0;
    end
    done3 = p_valid3 & ready3;
    @(negedge clk);
    cyc++;
    if (valid3 != '0 && p_valid3 == '0) begin
      v3_log.push_back(valid3);
      d3_log.push_back(data3);
    end
    if (rd3) a3_log.push_back(int'(addr3));
    p_rd = i_mem_rd_enable; p_addr = i_mem_addr; p_fetch = fetch; p_rst = rst;
    p_valid = instr_valid; p_ready = instr_ready;
    p_rd3 = rd3; p_addr3 = addr3; p_valid3 = valid3;
    model_step();
  endtask

  task automatic wait_cnt(input logic [15:0] target, input string name);
    for (int i = 0; i < 400 && instr_cnt != target; i++) cycle();
    check_eq(name, instr_cnt, target);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 100 && busy; i++) cycle();
    check_eq(name, busy, 0);
  endtask

  initial begin
    int base, run, n;
    for (int i = 0; i < 16; i++) begin
      mem[i] = 16'(i) | 16'h0100;
      mem3[i] = '0;
    end
    mem[0] = 16'h8001; mem[1] = 16'h4002; mem[2] = 16'hC003; mem[3] = 16'h0004;
    mem3[0] = 16'hC001; mem3[1] = 16'h4002;

    // Reset state
    cycle(); cycle();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_valid", instr_valid, 0);
    check_eq("rst_cnt", instr_cnt, 0);
    check_eq("rst_addr", i_mem_addr, 0);
    check_eq("rst_rd", i_mem_rd_enable, 0);
    check_eq("rst_fetch", fetch, 0);
    check_eq("rst_data", instr_data, 0);
    check_eq("rst_errs", {err_illegal, err_timeout}, 0);
    rst = 1'b0;

    // 1: three-instruction programme, then refill
    prog_len = 5'd3;
    acc_enable = 1'b1;
    cycle();
    check_eq("t1_fetch", fetch, 1);
    wait_cnt(16'd3, "t1_cnt");
    check_eq("t1_nreads", rd_log.size(), 3);
    check_eq("t1_reads", {rd_log[0][3:0], rd_log[1][3:0], rd_log[2][3:0]}, 12'h012);
    check_eq("t1_units", {hs_log[0], hs_log[1], hs_log[2]}, 12'h428);
    check_eq("t1_period", rd_cyc_log[1] - rd_cyc_log[0], RDL + 4);
    // 2: held ready and a stray done from unit 1 on the refilled address 0
    ready_delay = 5; done_delay = 3; distract = 4'b0010;
    cycle();
    check_eq("t1_refill_fetch", fetch, 1);
    check_eq("t1_refill_addr", i_mem_addr, 0);
    for (int i = 0; i < 100 && instr_valid == '0; i++) cycle();
    run = 0;
    while (instr_valid == 4'b0100 && run < 20) begin
      run++;
      cycle();
    end
    check_eq("t2_valid_cycles", run, 6);
    cycle(); cycle();
    check_eq("t2_stray_done", {busy, instr_cnt}, {1'b1, 16'd3});
    wait_cnt(16'd4, "t2_cnt");
    ready_delay = 0; done_delay = 0; distract = '0;
    acc_enable = 1'b0;
    wait_idle("t2_stop");
    check_eq("t2_stop_addr", i_mem_addr, 0);

    // prog_len of zero leaves the FSM idle
    flush();
    prog_len = '0;
    acc_enable = 1'b1;
    cycle(); cycle(); cycle();
    check_eq("len0_idle", {busy, fetch}, 0);

    // 4: drop acc_enable during EXEC of address 1
    acc_enable = 1'b0;
    cycle();
    prog_len = 5'd4;
    done_delay = 2;
    base = hs_cnt;
    acc_enable = 1'b1;
    for (int i = 0; i < 200 && hs_cnt < base + 2; i++) cycle();
    check_eq("t4_second_hs", hs_cnt, base + 2);
    cycle();
    acc_enable = 1'b0;
    wait_idle("t4_idle");
    check_eq("t4_cnt", instr_cnt, 6);
    check_eq("t4_addr", i_mem_addr, 1);
    done_delay = 0;

    // 5: reset while in DISPATCH, then resume
    flush();
    ready_delay = 3;
    acc_enable = 1'b1;
    for (int i = 0; i < 200 && instr_valid == '0; i++) cycle();
    check_eq("t5_in_dispatch", instr_valid, 4'b0100);
    rst = 1'b1;
    cycle();
    check_eq("t5_rst_outs", {busy, instr_valid, i_mem_addr, instr_cnt, instr_data}, 0);
    check_eq("t5_rst_strobes", {fetch, i_mem_rd_enable}, 0);
    rst = 1'b0;
    ready_delay = 0;
    wait_cnt(16'd4, "t5_resume_cnt");
    acc_enable = 1'b0;
    wait_idle("t5_idle");

    // 6: unit never completes
    flush();
    done_en = 0;
    base = hs_cnt;
    acc_enable = 1'b1;
    for (int i = 0; i < 200 && hs_cnt == base; i++) cycle();
`ifdef DISPATCH_TIMEOUT_EN
    n = 0;
    while (busy && n < 100) begin
      cycle();
      n++;
    end
    acc_enable = 1'b0;
    check_eq("t6_abort_cycle", n, 17);
    check_eq("t6_timeout", err_timeout, 1);
    check_eq("t6_cnt", instr_cnt, 4);
    pend = 0;
    flush();
    done_en = 1;
`else
    for (int i = 0; i < 40; i++) cycle();
    check_eq("t6_still_busy", {busy, err_timeout}, 2'b10);
    check_eq("t6_cnt_hold", instr_cnt, 4);
    done_en = 1;
    wait_cnt(16'd5, "t6_late_done");
    acc_enable = 1'b0;
    wait_idle("t6_idle");
`endif

    // 3: three units, address 0 carries sel=3
    check_eq("t3_ill_before", ill3, 0);
    len3 = 5'd2;
    acc3 = 1'b1;
    for (int i = 0; i < 100 && cnt3 == 16'd0; i++) cycle();
    acc3 = 1'b0;
    check_eq("t3_illegal", ill3, 1);
    check_eq("t3_cnt", cnt3, 1);
    check_eq("t3_ndispatch", v3_log.size(), 1);
    check_eq("t3_unit", v3_log[0], 3'b010);
    check_eq("t3_data", d3_log[0], 16'h4002);
    check_eq("t3_reads", {a3_log.size() >= 2, a3_log[0][3:0], a3_log[1][3:0]}, 9'h101);
    cycle(); cycle();
    check_eq("t3_idle", busy3, 0);
    check_eq("main_no_illegal", err_illegal, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
